// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified instruction/data memory between the
//   instruction-fetch requester and the data requester. Each access is
//   sequenced IDLE -> BUSY (wait for mem_ready) -> DONE (done pulse).
//   Data has fixed priority over fetch; after STARVE_MAX consecutive data
//   grants made while fetch was waiting, fetch is forced to win.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch request (held until if_done) and address
//   if_done/if_rdata      one-cycle completion pulse, registered fetch data
//   dm_req/dm_we/dm_addr/dm_wdata
//                         data request (held until dm_done), 1 = store
//   dm_done/dm_rdata      one-cycle completion pulse, registered load data
//   mem_en/mem_we/mem_addr/mem_wdata
//                         memory strobe and command, held for the whole access
//   mem_rdata/mem_ready   memory read data, valid when mem_ready=1
//   busy                  high whenever the FSM is not idle
//   owner                 0 = fetch, 1 = data; last/current grantee
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       starved;
    logic       pick_data;

    // Fetch is starved once the counter has reached its limit while it waits.
    always_comb begin
        starved   = if_req && (starve_cnt == 4'(STARVE_MAX));
        pick_data = dm_req && !starved;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            if_done    <= 1'b0;
            if_rdata   <= '0;
            dm_done    <= 1'b0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            owner      <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!if_req)
                        starve_cnt <= '0;
                    if (pick_data) begin
                        state     <= BUSY;
                        busy      <= 1'b1;
                        owner     <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        // Only data grants that overtake a waiting fetch count.
                        if (if_req && (starve_cnt < 4'(STARVE_MAX)))
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (if_req) begin
                        state      <= BUSY;
                        busy       <= 1'b1;
                        owner      <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner) begin
                            dm_done <= 1'b1;
                            // A store leaves the previous load data in place.
                            if (!mem_we)
                                dm_rdata <= mem_rdata;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester and memory models,
// scoreboards for grants and completions, plus directed cycle checks.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        owner;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_done(if_done),
        .if_rdata(if_rdata),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_done(dm_done),
        .dm_rdata(dm_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy(busy),
        .owner(owner)
    );

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } done_t;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    done_t       exp_d[$];
    gnt_t        exp_g[$];
    logic [31:0] fq[$];
    dreq_t       dq[$];

    int checks   = 0;
    int failures = 0;
    int lat      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_fetch(input logic [31:0] addr, input logic [31:0] rdata);
        exp_g.push_back('{owner: 1'b0, we: 1'b0, addr: addr, wdata: 32'h0});
        exp_d.push_back('{is_data: 1'b0, rdata: rdata});
    endtask

    task automatic exp_data(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata);
        exp_g.push_back('{owner: 1'b1, we: we, addr: addr, wdata: wdata});
        exp_d.push_back('{is_data: 1'b1, rdata: rdata});
    endtask

    // Memory content: one instruction at 0x10, otherwise a recognisable pattern.
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a == 32'h10) return 32'h8C22_0004;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: ready after `lat` extra BUSY cycles; garbage data on stores.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_en) begin
                if (wcnt == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_we ? 32'hFFFF_FFFF : rd(mem_addr);
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Fetch requester: holds if_req until it sees if_done, then takes the next item.
    initial begin
        logic d;
        if_req  = 1'b0;
        if_addr = '0;
        forever begin
            @(negedge clk);
            d = if_done;
            @(posedge clk);
            #1;
            if (d) if_req = 1'b0;
            if (!if_req && fq.size() > 0) begin
                if_addr = fq.pop_front();
                if_req  = 1'b1;
            end
        end
    end

    // Data requester: same handshake as the fetch requester.
    initial begin
        logic  d;
        dreq_t r;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        forever begin
            @(negedge clk);
            d = dm_done;
            @(posedge clk);
            #1;
            if (d) dm_req = 1'b0;
            if (!dm_req && dq.size() > 0) begin
                r        = dq.pop_front();
                dm_we    = r.we;
                dm_addr  = r.addr;
                dm_wdata = r.wdata;
                dm_req   = 1'b1;
            end
        end
    end

    // Completion monitor.
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (if_done || dm_done) begin
                chk("done_exclusive", {63'd0, if_done & dm_done}, 64'd0);
                if (exp_d.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual if_done=%0b dm_done=%0b required none",
                             if_done, dm_done);
                end else begin
                    e = exp_d.pop_front();
                    chk("done_owner", {63'd0, dm_done}, {63'd0, e.is_data});
                    chk("done_rdata", dm_done ? dm_rdata : if_rdata, {32'd0, e.rdata});
                end
            end
        end
    end

    // Grant monitor: every rising mem_en is a new grant.
    initial begin
        logic prev_en;
        gnt_t g;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_en && !prev_en) begin
                if (exp_g.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual addr=0x%0h required none", mem_addr);
                end else begin
                    g = exp_g.pop_front();
                    chk("grant_owner", {63'd0, owner}, {63'd0, g.owner});
                    chk("grant_we", {63'd0, mem_we}, {63'd0, g.we});
                    chk("grant_addr", {32'd0, mem_addr}, {32'd0, g.addr});
                    chk("grant_wdata", {32'd0, mem_wdata}, {32'd0, g.wdata});
                end
            end
            prev_en = mem_en;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Advance to the cycle in which if_req first reads high (cycle 0).
    task automatic sync_if(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (if_req) begin
                found = 1;
                break;
            end
        end
        chk({tag, "_sync"}, {63'd0, found}, 64'd1);
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (exp_d.size() == 0 && exp_g.size() == 0 && fq.size() == 0 &&
                dq.size() == 0 && !if_req && !dm_req && !busy)
                break;
            cyc();
        end
        chk({tag, "_drain"}, 64'(exp_d.size() + exp_g.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_owner", {63'd0, owner}, 64'd0);
        chk("rst_dones", {62'd0, if_done, dm_done}, 64'd0);
        chk("rst_if_rdata", {32'd0, if_rdata}, 64'd0);
        chk("rst_dm_rdata", {32'd0, dm_rdata}, 64'd0);
        reset = 1'b0;
        cyc();

        // 1: single fetch, zero wait states.
        lat = 0;
        exp_fetch(32'h10, 32'h8C22_0004);
        fq.push_back(32'h10);
        sync_if("t1");
        cyc();
        chk("t1_c1_mem_en", {63'd0, mem_en}, 64'd1);
        chk("t1_c1_busy", {63'd0, busy}, 64'd1);
        cyc();
        chk("t1_c2_mem_en", {63'd0, mem_en}, 64'd0);
        chk("t1_c2_if_done", {63'd0, if_done}, 64'd1);
        chk("t1_c2_if_rdata", {32'd0, if_rdata}, 64'h8C22_0004);
        chk("t1_c2_owner", {63'd0, owner}, 64'd0);
        cyc();
        chk("t1_c3_if_done", {63'd0, if_done}, 64'd0);
        chk("t1_c3_mem_en", {63'd0, mem_en}, 64'd0);
        chk("t1_c3_busy", {63'd0, busy}, 64'd0);
        drain("t1", 40);

        // 2: simultaneous requests, data store wins first.
        exp_data(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
        exp_fetch(32'h14, 32'hC0DE_0014);
        fq.push_back(32'h14);
        dq.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEAD_BEEF});
        sync_if("t2");
        cyc();
        chk("t2_c1_owner", {63'd0, owner}, 64'd1);
        chk("t2_c1_mem_we", {63'd0, mem_we}, 64'd1);
        chk("t2_c1_mem_wdata", {32'd0, mem_wdata}, 64'hDEAD_BEEF);
        drain("t2", 40);
        chk("t2_dm_rdata_kept", {32'd0, dm_rdata}, 64'd0);

        // 3: starvation guard, fetch held throughout.
        for (int i = 0; i < 4; i++)
            exp_data(1'b0, 32'h500 + 32'(4 * i), 32'h0, 32'hC0DE_0500 + 32'(4 * i));
        exp_fetch(32'h40, 32'hC0DE_0040);
        for (int i = 4; i < 8; i++)
            exp_data(1'b0, 32'h500 + 32'(4 * i), 32'h0, 32'hC0DE_0500 + 32'(4 * i));
        exp_fetch(32'h44, 32'hC0DE_0044);
        exp_data(1'b0, 32'h520, 32'h0, 32'hC0DE_0520);
        fq.push_back(32'h40);
        fq.push_back(32'h44);
        for (int i = 0; i < 9; i++)
            dq.push_back('{we: 1'b0, addr: 32'h500 + 32'(4 * i), wdata: 32'h0});
        drain("t3", 200);
        chk("t3_dm_rdata_last", {32'd0, dm_rdata}, 64'hC0DE_0520);

        // 4: five BUSY cycles; a data request raised mid-access waits.
        lat = 4;
        exp_fetch(32'h200, 32'hC0DE_0200);
        exp_data(1'b0, 32'h600, 32'h0, 32'hC0DE_0600);
        fq.push_back(32'h200);
        sync_if("t4");
        for (int c = 1; c <= 5; c++) begin
            cyc();
            chk("t4_busy_mem_en", {63'd0, mem_en}, 64'd1);
            chk("t4_busy_mem_addr", {32'd0, mem_addr}, 64'h200);
            chk("t4_busy_if_done", {63'd0, if_done}, 64'd0);
            if (c == 2)
                dq.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0});
        end
        cyc();
        chk("t4_c6_if_done", {63'd0, if_done}, 64'd1);
        chk("t4_c6_mem_en", {63'd0, mem_en}, 64'd0);
        cyc();
        chk("t4_c7_mem_en", {63'd0, mem_en}, 64'd0);
        cyc();
        chk("t4_c8_mem_en", {63'd0, mem_en}, 64'd1);
        chk("t4_c8_owner", {63'd0, owner}, 64'd1);
        chk("t4_c8_mem_addr", {32'd0, mem_addr}, 64'h600);
        drain("t4", 60);

        // 5: reset during the second BUSY cycle; the held fetch is re-granted.
        lat = 3;
        exp_g.push_back('{owner: 1'b0, we: 1'b0, addr: 32'h300, wdata: 32'h0});
        exp_fetch(32'h300, 32'hC0DE_0300);
        fq.push_back(32'h300);
        sync_if("t5");
        cyc();
        chk("t5_c1_mem_en", {63'd0, mem_en}, 64'd1);
        cyc();
        chk("t5_c2_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        cyc();
        chk("t5_c3_mem_en", {63'd0, mem_en}, 64'd0);
        chk("t5_c3_busy", {63'd0, busy}, 64'd0);
        chk("t5_c3_dones", {62'd0, if_done, dm_done}, 64'd0);
        reset = 1'b0;
        cyc();
        chk("t5_c4_mem_en", {63'd0, mem_en}, 64'd1);
        chk("t5_c4_mem_addr", {32'd0, mem_addr}, 64'h300);
        drain("t5", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the instruction-fetch (IF) requester and the data requester (loads, stores, stack push/pop).
- Sequences each memory transaction with a req/done handshake and supports variable memory latency via mem_ready.
- Sits between the control path and the memory, alongside the processor datapath.
- Data has fixed priority over fetch, with a starvation guard so fetch always progresses.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive data grants, with fetch pending, after which fetch is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch address; stable while if_req
if_done  out  1  one-cycle pulse; fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched instruction, registered
dm_req  in  1  data request; held until dm_done
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_done  out  1  one-cycle pulse; data access complete
dm_rdata  out  DATA_W  load data, registered
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completes the access this cycle
busy  out  1  state != IDLE
owner  out  1  0 = fetch, 1 = data; last/current grantee

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, all outputs 0, starvation counter 0.
- Reset mid-transaction: next cycle mem_en=0, state=IDLE, no done pulse. The aborted access is lost; requesters re-request.
- Three-state FSM:
  - IDLE:
    - If no request, stay in IDLE.
    - Otherwise pick a winner and latch addr, we and wdata into mem_* together with mem_en=1; go to BUSY.
    - Winner rule: if both requests are pending, data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
    - If only one request is pending, that requester wins.
    - owner is set to the winner.
  - BUSY:
    - mem_en/mem_we/mem_addr/mem_wdata are held constant.
    - When mem_ready=1: drop mem_en and mem_we, capture mem_rdata into the winner's rdata register (loads and fetches only; dm_rdata is unchanged on a store), go to DONE.
    - No timeout; BUSY waits indefinitely.
  - DONE:
    - The winner's done=1 for exactly this cycle; go to IDLE.
- Requester rule: a requester drops req (or presents a new request) in the cycle after it samples done=1, so IDLE never re-grants a completed request.
- Latency, minimum 3 cycles per transaction:
  - req is high in cycle 0, so mem_en is high in cycle 1.
  - mem_ready arriving in cycle k (k≥1) gives done in cycle k+1.
  - The earliest next mem_en is cycle k+3.
- Fetch uses mem_we=0 and mem_wdata=0. A data store uses mem_we=dm_we=1.
- Starvation counter (4 bits, saturating at STARVE_MAX):
  - Increments on each data grant made while if_req=1.
  - Clears on a fetch grant, or when if_req=0 in IDLE.
- if_done and dm_done are never high in the same cycle.
- Requests arriving while BUSY or DONE wait for IDLE; they are not lost.

Test Plan:
1. Reset, then if_req=1 with if_addr=0x0000_0010, memory returns 0x8C22_0004 with mem_ready high the first BUSY cycle → mem_en high in cycle 1 only, if_done pulses in cycle 2, if_rdata=0x8C22_0004, owner=0.
2. Both requests high in the same cycle, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF → data is granted first with mem_we=1, mem_wdata=0xDEADBEEF, dm_done pulses and dm_rdata stays 0; fetch is granted in the next IDLE.
3. Starvation: if_req held, dm_req re-asserted immediately after every dm_done, STARVE_MAX=4 → exactly 4 data grants, then a fetch grant, then the counter is back at 0.
4. Wait states: mem_ready delayed 5 cycles → mem_addr and mem_en stay stable for all 5 BUSY cycles; done arrives the cycle after mem_ready; a dm_req raised during BUSY is granted only after DONE→IDLE.
5. reset asserted on the 2nd BUSY cycle → mem_en=0, busy=0 and no done on the next cycle; after release, a still-held request is granted normally.
